buzzer_seq: RTL

Parametrised beep-pattern generator driving the board piezo from the single system clock. It derives its own millisecond time base and tone divider internally, so no separate slow clock is needed. It plays a programmable count of tone bursts with on/off durations and tone pitch latched at start, then reports completion. It sits between the game-control FSM (event sounds: move, capture, error, timeout) and the buzzer pin.

---
 rtl/buzzer_pkg.sv | 18 +
 rtl/buzzer_tick_gen.sv | 35 +++
 rtl/buzzer_seq.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer sequencer and related timers.
package buzzer_pkg;

    localparam int DEFAULT_CLK_HZ  = 1_000_000;
    localparam int DEFAULT_TICK_HZ = 1_000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } buzzer_state_t;

    // Number of system clocks per time-base tick.
    function automatic int tick_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/buzzer_tick_gen.sv
// Time-base prescaler: counts 0..TICKDIV-1 and flags the terminal count.
module buzzer_tick_gen #(
    parameter int TICKDIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICKDIV > 2) ? $clog2(TICKDIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKDIV - 1);

    logic [CW-1:0] count;

    // Free-running prescaler with synchronous clear, advancing only while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    // Tick is independent of clear so the user can clear on tick without a loop.
    assign tick = enable && (count == LAST);

endmodule

// File: rtl/buzzer_seq.sv
// Beep-pattern generator: plays repeat_n tone bursts with on/off gaps.
module buzzer_seq
    import buzzer_pkg::*;
#(
    parameter int CLK_HZ  = DEFAULT_CLK_HZ,
    parameter int TICK_HZ = DEFAULT_TICK_HZ,
    parameter int DIV_W   = 16,
    parameter int MS_W    = 10,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] half_period,
    input  logic [MS_W-1:0]  on_ticks,
    input  logic [MS_W-1:0]  off_ticks,
    input  logic [CNT_W-1:0] repeat_n,
    output logic             busy,
    output logic             done,
    output logic             buzzer_out
);

    localparam int TICKDIV = tick_div(CLK_HZ, TICK_HZ);

    buzzer_state_t    state;
    logic [DIV_W-1:0] hp_lat;
    logic [MS_W-1:0]  on_lat;
    logic [MS_W-1:0]  off_lat;
    logic [CNT_W-1:0] rep_lat;
    logic [DIV_W-1:0] tone_cnt;
    logic [MS_W-1:0]  tick_cnt;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] burst_next;
    logic             tick;
    logic             tick_clear;
    logic             on_end;
    logic             off_end;

    buzzer_tick_gen #(
        .TICKDIV (TICKDIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (state != IDLE),
        .clear  (tick_clear),
        .tick   (tick)
    );

    // Phase-end detection; the prescaler restarts on every state change.
    always_comb begin
        burst_next = burst_cnt + 1'b1;
        on_end     = (state == ON)  && tick && (tick_cnt == on_lat - MS_W'(1));
        off_end    = (state == OFF) && tick && (tick_cnt == off_lat - MS_W'(1));
        tick_clear = (state == IDLE) || stop || on_end || off_end;
    end

    // Main sequencer: state, tone divider, tick/burst counters and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hp_lat     <= '0;
            on_lat     <= '0;
            off_lat    <= '0;
            rep_lat    <= '0;
            tone_cnt   <= '0;
            tick_cnt   <= '0;
            burst_cnt  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            buzzer_out <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        hp_lat     <= (half_period == '0) ? DIV_W'(1) : half_period;
                        on_lat     <= (on_ticks == '0) ? MS_W'(1) : on_ticks;
                        off_lat    <= off_ticks;
                        rep_lat    <= repeat_n;
                        tone_cnt   <= '0;
                        tick_cnt   <= '0;
                        burst_cnt  <= '0;
                        buzzer_out <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ON;
                    end
                end
                ON: begin
                    if (stop) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        buzzer_out <= 1'b0;
                        tone_cnt   <= '0;
                        tick_cnt   <= '0;
                    end else if (on_end) begin
                        burst_cnt  <= burst_next;
                        tick_cnt   <= '0;
                        tone_cnt   <= '0;
                        buzzer_out <= 1'b0;
                        if ((rep_lat != '0) && (burst_next == rep_lat)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (off_lat != '0) begin
                            state <= OFF;
                        end else begin
                            state <= ON;
                        end
                    end else begin
                        if (tick) begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                        if (tone_cnt == hp_lat - DIV_W'(1)) begin
                            tone_cnt   <= '0;
                            buzzer_out <= ~buzzer_out;
                        end else begin
                            tone_cnt <= tone_cnt + 1'b1;
                        end
                    end
                end
                OFF: begin
                    if (stop) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        buzzer_out <= 1'b0;
                        tick_cnt   <= '0;
                    end else if (off_end) begin
                        state      <= ON;
                        tick_cnt   <= '0;
                        tone_cnt   <= '0;
                        buzzer_out <= 1'b0;
                    end else if (tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    buzzer_out <= 1'b0;
                end
            endcase
        end
    end

endmodule
